// File: rtl/dvp_window_crop.sv
// Rectangular crop of a DVP pixel stream. The window is latched from cfg_* at every
// frame start. EN=0 gives a registered bypass; the counters and latching keep running.
module dvp_window_crop #(
    parameter int            CW    = 12,
    parameter logic [CW-1:0] DEF_X = CW'(0),
    parameter logic [CW-1:0] DEF_Y = CW'(0),
    parameter logic [CW-1:0] DEF_W = CW'(1280),
    parameter logic [CW-1:0] DEF_H = CW'(720)
) (
    input  logic          pre_clk,
    input  logic          rst_n,
    input  logic          EN,
    input  logic [CW-1:0] cfg_x,
    input  logic [CW-1:0] cfg_y,
    input  logic [CW-1:0] cfg_w,
    input  logic [CW-1:0] cfg_h,
    input  logic          pre_vs,
    input  logic          pre_de,
    input  logic [23:0]   pre_data,
    output logic          post_clk,
    output logic          post_vs,
    output logic          post_de,
    output logic [23:0]   post_data,
    output logic          synced
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          vs_d, de_d;
    logic [CW-1:0] x_cnt, y_cnt;
    logic [CW-1:0] sx, sy, sw, sh;
    logic          vs_rise, de_fall;
    logic [CW:0]   x_end, y_end;
    logic          in_x, in_y, crop_de;

    assign post_clk = pre_clk;

    assign vs_rise = pre_vs & ~vs_d;
    assign de_fall = ~pre_de & de_d;

    // Window ends are one bit wider so a window running past 2^CW-1 cannot wrap to zero.
    assign x_end   = {1'b0, sx} + {1'b0, sw};
    assign y_end   = {1'b0, sy} + {1'b0, sh};
    assign in_x    = (x_cnt >= sx) && ({1'b0, x_cnt} < x_end);
    assign in_y    = (y_cnt >= sy) && ({1'b0, y_cnt} < y_end);
    assign crop_de = pre_de & in_x & in_y & synced;

    always_ff @(posedge pre_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            sx        <= DEF_X;
            sy        <= DEF_Y;
            sw        <= DEF_W;
            sh        <= DEF_H;
            synced    <= 1'b0;
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= 24'h000000;
        end else begin
            vs_d    <= pre_vs;
            de_d    <= pre_de;
            post_vs <= pre_vs;

            // A frame start overrides any counter update on the same cycle.
            if (vs_rise) begin
                sx     <= cfg_x;
                sy     <= cfg_y;
                sw     <= cfg_w;
                sh     <= cfg_h;
                x_cnt  <= '0;
                y_cnt  <= '0;
                synced <= 1'b1;
            end else begin
                if (de_fall)
                    x_cnt <= '0;
                else if (pre_de && (x_cnt != CNT_MAX))
                    x_cnt <= x_cnt + 1'b1;

                if (de_fall && (y_cnt != CNT_MAX))
                    y_cnt <= y_cnt + 1'b1;
            end

            if (EN) begin
                post_de   <= crop_de;
                post_data <= crop_de ? pre_data : 24'h000000;
            end else begin
                post_de   <= pre_de;
                post_data <= pre_de ? pre_data : 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_dvp_window_crop.sv
// Bench for dvp_window_crop. Frames are generated with known line/pixel indices, and a
// reference model predicts each output from the window rules and the config latched at frame start.
module tb_dvp_window_crop;

    logic        pre_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b1;
    logic [11:0] cfg_x   = 12'd0;
    logic [11:0] cfg_y   = 12'd0;
    logic [11:0] cfg_w   = 12'd0;
    logic [11:0] cfg_h   = 12'd0;
    logic        pre_vs  = 1'b0;
    logic        pre_de  = 1'b0;
    logic [23:0] pre_data = 24'h0;
    logic        post_clk, post_vs, post_de, synced;
    logic [23:0] post_data;

    int checks = 0;
    int errors = 0;

    int m_sx = 0, m_sy = 0, m_sw = 1280, m_sh = 720;
    bit m_synced  = 1'b0;
    bit m_prev_vs = 1'b0;
    int frame_out = 0;
    int nxt_x = 0, nxt_y = 0, nxt_w = 0, nxt_h = 0;

    dvp_window_crop dut (
        .pre_clk   (pre_clk),
        .rst_n     (rst_n),
        .EN        (en),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .pre_vs    (pre_vs),
        .pre_de    (pre_de),
        .pre_data  (pre_data),
        .post_clk  (post_clk),
        .post_vs   (post_vs),
        .post_de   (post_de),
        .post_data (post_data),
        .synced    (synced)
    );

    always #5 pre_clk = ~pre_clk;

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_sx = 0; m_sy = 0; m_sw = 1280; m_sh = 720;
        m_synced  = 1'b0;
        m_prev_vs = 1'b0;
    endtask

    // Length of the overlap between [s, s+w) and [0, n).
    function automatic int ovl(input int s, input int w, input int n);
        int hi, lo;
        hi = (s + w < n) ? s + w : n;
        lo = (s < n) ? s : n;
        return (hi > lo) ? hi - lo : 0;
    endfunction

    // Drives one cycle, predicts the registered result, then checks it just after the edge.
    task automatic applyStimulus(input bit vs, input bit de, input int line, input int pix,
                                 input logic [23:0] data);
        logic        exp_de;
        logic [23:0] exp_data;
        bit          inwin;
        pre_vs   = vs;
        pre_de   = de;
        pre_data = de ? data : 24'h0;
        inwin    = (pix >= m_sx) && (pix < m_sx + m_sw) && (line >= m_sy) && (line < m_sy + m_sh);
        exp_de   = en ? (de && m_synced && inwin) : de;
        exp_data = exp_de ? data : 24'h0;
        if (vs && !m_prev_vs) begin
            m_sx = int'(cfg_x); m_sy = int'(cfg_y); m_sw = int'(cfg_w); m_sh = int'(cfg_h);
            m_synced = 1'b1;
        end
        m_prev_vs = vs;
        @(posedge pre_clk);
        #1;
        checkOutput("post_vs", 24'(post_vs), 24'(vs));
        checkOutput("post_de", 24'(post_de), 24'(exp_de));
        checkOutput("post_data", post_data, exp_data);
        checkOutput("synced", 24'(synced), 24'(m_synced));
        if (post_de === 1'b1) frame_out++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, 24'h0);
    endtask

    task automatic frameStart();
        idle(2);
        repeat (2) applyStimulus(1'b1, 1'b0, 0, 0, 24'h0);
        idle(2);
    endtask

    task automatic runFrame(input int lines, input int ppl, input bit rnd, input int chg_line);
        int exp_cnt;
        frame_out = 0;
        frameStart();
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++)
                applyStimulus(1'b0, 1'b1, l, p, rnd ? 24'($urandom) : {12'(l), 12'(p)});
            idle(3);
            if (l == chg_line) begin
                cfg_x = 12'(nxt_x); cfg_y = 12'(nxt_y); cfg_w = 12'(nxt_w); cfg_h = 12'(nxt_h);
            end
        end
        if (!en)
            exp_cnt = lines * ppl;
        else
            exp_cnt = m_synced ? ovl(m_sx, m_sw, ppl) * ovl(m_sy, m_sh, lines) : 0;
        checkOutput("frame_pixels", 24'(frame_out), 24'(exp_cnt));
    endtask

    task automatic setCfg(input int x, input int y, input int w, input int h);
        cfg_x = 12'(x); cfg_y = 12'(y); cfg_w = 12'(w); cfg_h = 12'(h);
    endtask

    initial begin
        $display("[TB] start");
        modelReset();
        setCfg(2, 1, 4, 2);
        repeat (2) @(posedge pre_clk);
        #1;
        checkOutput("reset_post_vs", 24'(post_vs), 24'h0);
        checkOutput("reset_post_de", 24'(post_de), 24'h0);
        checkOutput("reset_post_data", post_data, 24'h0);
        checkOutput("reset_synced", 24'(synced), 24'h0);
        rst_n = 1'b1;

        $display("[TB] basic crop and bypass");
        en = 1'b1;
        runFrame(4, 10, 1'b0, -1);
        en = 1'b0;
        runFrame(4, 10, 1'b0, -1);
        en = 1'b1;

        $display("[TB] mid-frame config change");
        nxt_x = 0; nxt_y = 0; nxt_w = 3; nxt_h = 1;
        runFrame(4, 10, 1'b0, 1);
        runFrame(4, 10, 1'b0, -1);

        $display("[TB] partial and empty windows");
        setCfg(8, 0, 6, 1);
        runFrame(4, 10, 1'b0, -1);
        setCfg(2, 1, 0, 2);
        runFrame(4, 10, 1'b0, -1);
        setCfg(20, 6, 4, 2);
        runFrame(4, 10, 1'b0, -1);

        $display("[TB] reset mid-line");
        setCfg(0, 0, 10, 4);
        frameStart();
        for (int p = 0; p < 5; p++)
            applyStimulus(1'b0, 1'b1, 0, p, {12'd0, 12'(p)});
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_post_vs", 24'(post_vs), 24'h0);
        checkOutput("midrst_post_de", 24'(post_de), 24'h0);
        checkOutput("midrst_post_data", post_data, 24'h0);
        checkOutput("midrst_synced", 24'(synced), 24'h0);
        modelReset();
        repeat (2) @(posedge pre_clk);
        #1;
        rst_n = 1'b1;
        frame_out = 0;
        for (int p = 5; p < 10; p++)
            applyStimulus(1'b0, 1'b1, 0, p, {12'd0, 12'(p)});
        idle(3);
        for (int p = 0; p < 10; p++)
            applyStimulus(1'b0, 1'b1, 1, p, {12'd1, 12'(p)});
        idle(3);
        checkOutput("post_reset_suppressed", 24'(frame_out), 24'h0);
        runFrame(4, 10, 1'b0, -1);

        $display("[TB] window at coordinate limit");
        setCfg(4090, 0, 10, 1);
        runFrame(1, 4095, 1'b0, -1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            en = 1'($urandom_range(0, 3) != 0);
            setCfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 5)));
            runFrame(5, 10, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvp_window_crop.md
Name: dvp_window_crop

Overview:
- Upstream neighbour of the line filler in the DVP video path.
- Takes the raw camera pixel stream and forwards only pixels inside a rectangular window, with the window origin and size configured at run time.
- Its output lines are shorter than the panel width; the filler then pads them with black to H_DISP.
- Includes a bypass mode and frame-synchronous configuration latching.

Parameters:
- CW, 12, width of coordinate and size fields (max 4095).
- DEF_X, 12'd0, window X start loaded at reset.
- DEF_Y, 12'd0, window Y start loaded at reset.
- DEF_W, 12'd1280, window width loaded at reset.
- DEF_H, 12'd720, window height loaded at reset.

Ports:
- pre_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EN  in  1  1 = crop active, 0 = registered bypass.
- cfg_x  in  CW  window X start, in pixels within an active line.
- cfg_y  in  CW  window Y start, in active lines within a frame.
- cfg_w  in  CW  window width in pixels.
- cfg_h  in  CW  window height in lines.
- pre_vs  in  1  vertical sync, active high; rising edge = frame start.
- pre_de  in  1  data enable, high during active pixels.
- pre_data  in  24  RGB888 pixel.
- post_clk  out  1  equals pre_clk (direct assign).
- post_vs  out  1  pre_vs delayed 1 cycle.
- post_de  out  1  cropped data enable.
- post_data  out  24  cropped pixel; 24'h000000 whenever post_de = 0.
- synced  out  1  high once the first frame start after reset has been seen.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state go to:
  - post_vs = 0, post_de = 0, post_data = 0, synced = 0.
  - x_cnt = 0, y_cnt = 0, vs_d = 0, de_d = 0.
  - Shadow config = DEF_X / DEF_Y / DEF_W / DEF_H.
- Latency: every output except post_clk is registered, exactly 1 cycle after the corresponding input. post_vs, post_de and post_data stay mutually aligned.
- Edge detection uses internal registers vs_d and de_d.
  - vs_rise = pre_vs & ~vs_d.
  - de_fall = ~pre_de & de_d.
- On vs_rise:
  - Latch cfg_x/cfg_y/cfg_w/cfg_h into the shadow registers.
  - Clear x_cnt and y_cnt.
  - Set synced = 1.
  - The shadow config is used for the whole frame; cfg changes mid-frame have no effect until the next vs_rise.
  - Latching happens regardless of EN.
- x_cnt:
  - Increments on every cycle with pre_de = 1.
  - Clears on de_fall.
  - Saturates at 2^CW-1 and does not wrap.
- y_cnt:
  - Increments on de_fall.
  - Saturates at 2^CW-1.
  - If pre_de falls on the same cycle as vs_rise, the vs_rise clear wins.
- Window test (combinational on the current cycle's counters):
  - in_x = (x_cnt >= sx) && (x_cnt < sx + sw).
  - in_y = (y_cnt >= sy) && (y_cnt < sy + sh).
  - Both sums are computed at CW+1 bits, so a window extending beyond 4095 does not wrap.
- EN = 1:
  - post_de <= pre_de & in_x & in_y & synced.
  - post_data <= that same condition ? pre_data : 0.
- EN = 0:
  - post_de <= pre_de; post_data <= pre_data.
  - Counters and config latching keep running, so re-enabling at a frame boundary is clean.
- EN is sampled every cycle. Toggling it mid-line yields a partial line; this is allowed but is not a supported use.
- Boundary cases:
  - sw = 0 or sh = 0: no post_de for the whole frame.
  - Window fully outside the input frame: no post_de.
  - Window partially outside: only the overlapping pixels are output. Output lines are shorter than sw and the filler pads them.
  - pre_vs high while pre_de is high: treated as a normal frame start; the counters clear immediately.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - After release, cropped output stays suppressed (synced = 0) until the next vs_rise. Bypass output resumes at once.
- Line/frame structure: exactly one output line per input line that has in_y true and a non-empty intersection. Output pixels are contiguous within the line (no de gaps).

Test Plan:
- Reset, EN=1, cfg=(x=2, y=1, w=4, h=2), one frame of 4 lines × 10 pixels with pre_data = {y,x} → post_de on lines 1–2 only, 4 pixels each, data x=2..5, each 1 cycle after input; synced = 1.
- Same stimulus with EN=0 → post_de/post_data equal pre_de/pre_data delayed 1 cycle; all 40 pixels pass.
- Change cfg to (x=0, y=0, w=3, h=1) mid-frame → current frame still uses (2,1,4,2); the next frame outputs 3 pixels from line 0 only.
- cfg=(x=8, y=0, w=6, h=1) on 10-pixel lines → 2 pixels output (x=8, 9); cfg w=0 → no post_de for the frame.
- Assert rst_n low mid-line, then release → outputs 0 during reset; no post_de until the next pre_vs rise; the frame after that crops correctly.
- cfg=(x=4090, y=0, w=10, h=1) with 4095-pixel lines → pixels 4090–4094 output, with no wrap to x=0..3.
